// File: rtl/alu_pkg.sv
// Shared definitions for the ALU access arbiter: opcodes, unit-select field,
// flag bit positions, arbiter FSM encoding and the legal-opcode predicate.
package alu_pkg;

    localparam int OP_W = 6;

    // Opcode [5:4] selects the ALU unit, [3:0] the operation within it.
    localparam int UNIT_MSB = 5;
    localparam int UNIT_LSB = 4;

    localparam logic [1:0] UNIT_INT   = 2'd0;
    localparam logic [1:0] UNIT_FP    = 2'd1;
    localparam logic [1:0] UNIT_BIT   = 2'd2;
    localparam logic [1:0] UNIT_SHIFT = 2'd3;

    localparam logic [OP_W-1:0] OP_ADD  = 6'h00;
    localparam logic [OP_W-1:0] OP_SUB  = 6'h01;
    localparam logic [OP_W-1:0] OP_MUL  = 6'h02;
    localparam logic [OP_W-1:0] OP_DIV  = 6'h03;
    localparam logic [OP_W-1:0] OP_MOD  = 6'h04;
    localparam logic [OP_W-1:0] OP_FADD = 6'h10;
    localparam logic [OP_W-1:0] OP_FSUB = 6'h11;
    localparam logic [OP_W-1:0] OP_FMUL = 6'h12;
    localparam logic [OP_W-1:0] OP_AND  = 6'h20;
    localparam logic [OP_W-1:0] OP_OR   = 6'h21;
    localparam logic [OP_W-1:0] OP_XOR  = 6'h22;
    localparam logic [OP_W-1:0] OP_NOT  = 6'h23;
    localparam logic [OP_W-1:0] OP_SLL  = 6'h30;
    localparam logic [OP_W-1:0] OP_SRL  = 6'h31;
    localparam logic [OP_W-1:0] OP_SRA  = 6'h32;
    localparam logic [OP_W-1:0] OP_ROL  = 6'h33;

    localparam int FLAG_U_LESS    = 0;
    localparam int FLAG_U_GREATER = 1;
    localparam int FLAG_U_EQUAL   = 2;
    localparam int FLAG_LESS      = 3;
    localparam int FLAG_GREATER   = 4;
    localparam int FLAG_NOT_EQUAL = 5;
    localparam int FLAG_EQUAL     = 6;
    localparam int FLAG_OVERFLOW  = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op[UNIT_MSB:UNIT_LSB])
            UNIT_INT:   legal = (op[3:0] <= 4'd4);
            UNIT_FP:    legal = (op[3:0] <= 4'd2);
            UNIT_BIT:   legal = (op[3:0] <= 4'd3);
            UNIT_SHIFT: legal = (op[3:0] <= 4'd3);
            default:    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above
// the pointer, wrapping to the lowest request when none lie above it.
module alu_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [N-1:0] masked;
    logic [N-1:0] sel;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign masked[gi] = req[gi] && (IDX_W'(gi) >= ptr);
        end
    endgenerate

    // Isolate the lowest set bit of whichever vector is searched.
    assign sel   = (|masked) ? masked : req;
    assign grant = sel & (~sel + N'(1));

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) begin
                grant_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/alu_access_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin accept,
// one execute cycle, then a tagged valid/ready response.
// Optional macro ALU_ARB_OPCHECK_EN rejects illegal opcodes without executing.
module alu_access_arbiter
    import alu_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int NUM_REQ  = 2,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WORDSIZE-1:0]  req_input_a,
    input  logic [NUM_REQ*WORDSIZE-1:0]  req_input_b,
    input  logic [NUM_REQ*6-1:0]         req_operation,
    output logic [WORDSIZE-1:0]          alu_input_a,
    output logic [WORDSIZE-1:0]          alu_input_b,
    output logic [5:0]                   alu_operation,
    input  logic [WORDSIZE-1:0]          alu_result,
    input  logic [7:0]                   alu_flags,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [WORDSIZE-1:0]          rsp_result,
    output logic [7:0]                   rsp_flags,
    output logic                         rsp_error
);

    logic [WORDSIZE-1:0] a_slice  [NUM_REQ];
    logic [WORDSIZE-1:0] b_slice  [NUM_REQ];
    logic [5:0]          op_slice [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_slice[gi]  = req_input_a[gi*WORDSIZE +: WORDSIZE];
            assign b_slice[gi]  = req_input_b[gi*WORDSIZE +: WORDSIZE];
            assign op_slice[gi] = req_operation[gi*6 +: 6];
        end
    endgenerate

    arb_state_t          state_reg, state_next;
    logic [ID_W-1:0]     ptr_reg, ptr_next;
    logic [WORDSIZE-1:0] alu_a_reg, alu_a_next;
    logic [WORDSIZE-1:0] alu_b_reg, alu_b_next;
    logic [5:0]          alu_op_reg, alu_op_next;
    logic [ID_W-1:0]     id_reg, id_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic [WORDSIZE-1:0] rsp_result_reg, rsp_result_next;
    logic [7:0]          rsp_flags_reg, rsp_flags_next;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                accept;
    logic [WORDSIZE-1:0] sel_a;
    logic [WORDSIZE-1:0] sel_b;
    logic [5:0]          sel_op;
    logic [ID_W-1:0]     ptr_after;

    alu_rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = (state_reg == ST_IDLE) ? grant : '0;
    assign accept    = |req_ready;
    assign sel_a     = a_slice[grant_idx];
    assign sel_b     = b_slice[grant_idx];
    assign sel_op    = op_slice[grant_idx];
    assign ptr_after = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

`ifdef ALU_ARB_OPCHECK_EN
    logic rsp_error_reg, rsp_error_next;
`endif

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        alu_a_next      = alu_a_reg;
        alu_b_next      = alu_b_reg;
        alu_op_next     = alu_op_reg;
        id_next         = id_reg;
        rsp_valid_next  = rsp_valid_reg;
        rsp_result_next = rsp_result_reg;
        rsp_flags_next  = rsp_flags_reg;
`ifdef ALU_ARB_OPCHECK_EN
        rsp_error_next  = rsp_error_reg;
`endif
        unique case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    ptr_next   = ptr_after;
                    id_next    = grant_idx;
                    alu_a_next = sel_a;
                    alu_b_next = sel_b;
`ifdef ALU_ARB_OPCHECK_EN
                    // Illegal opcodes never reach the ALU; answer straight away.
                    if (!is_legal_op(sel_op)) begin
                        state_next      = ST_RESP;
                        rsp_valid_next  = 1'b1;
                        rsp_result_next = '0;
                        rsp_flags_next  = '0;
                        rsp_error_next  = 1'b1;
                    end else begin
                        alu_op_next = sel_op;
                        state_next  = ST_EXEC;
                    end
`else
                    alu_op_next = sel_op;
                    state_next  = ST_EXEC;
`endif
                end
            end
            ST_EXEC: begin
                rsp_result_next = alu_result;
                rsp_flags_next  = alu_flags;
                rsp_valid_next  = 1'b1;
`ifdef ALU_ARB_OPCHECK_EN
                rsp_error_next  = 1'b0;
`endif
                state_next      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= '0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_op_reg     <= '0;
            id_reg         <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_flags_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            alu_a_reg      <= alu_a_next;
            alu_b_reg      <= alu_b_next;
            alu_op_reg     <= alu_op_next;
            id_reg         <= id_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_result_reg <= rsp_result_next;
            rsp_flags_reg  <= rsp_flags_next;
        end
    end

`ifdef ALU_ARB_OPCHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_error_reg <= 1'b0;
        end else begin
            rsp_error_reg <= rsp_error_next;
        end
    end
    assign rsp_error = rsp_error_reg;
`else
    assign rsp_error = 1'b0;
`endif

    assign alu_input_a   = alu_a_reg;
    assign alu_input_b   = alu_b_reg;
    assign alu_operation = alu_op_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_id        = id_reg;
    assign rsp_result    = rsp_result_reg;
    assign rsp_flags     = rsp_flags_reg;

endmodule

// File: tb/tb_alu_access_arbiter.sv
// Directed bench for alu_access_arbiter with a small behavioural ALU attached.
// Expectations for the opcode scenario follow whether ALU_ARB_OPCHECK_EN is defined.
module tb_alu_access_arbiter;

    localparam int W   = 64;
    localparam int NR  = 2;
    localparam int IDW = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*W-1:0]   req_input_a = '0;
    logic [NR*W-1:0]   req_input_b = '0;
    logic [NR*6-1:0]   req_operation = '0;
    logic [W-1:0]      alu_input_a;
    logic [W-1:0]      alu_input_b;
    logic [5:0]        alu_operation;
    logic [W-1:0]      alu_result;
    logic [7:0]        alu_flags;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_result;
    logic [7:0]        rsp_flags;
    logic              rsp_error;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_access_arbiter #(.WORDSIZE(W), .NUM_REQ(NR), .ID_W(IDW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_input_a   (req_input_a),
        .req_input_b   (req_input_b),
        .req_operation (req_operation),
        .alu_input_a   (alu_input_a),
        .alu_input_b   (alu_input_b),
        .alu_operation (alu_operation),
        .alu_result    (alu_result),
        .alu_flags     (alu_flags),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result),
        .rsp_flags     (rsp_flags),
        .rsp_error     (rsp_error)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: add, sub, and/or/xor; any other opcode yields a|b.
    logic [W-1:0] m_res;
    logic         m_ovf;
    always_comb begin
        m_res = alu_input_a | alu_input_b;
        m_ovf = 1'b0;
        case (alu_operation)
            6'h00: begin
                m_res = alu_input_a + alu_input_b;
                m_ovf = (alu_input_a[W-1] == alu_input_b[W-1]) && (m_res[W-1] != alu_input_a[W-1]);
            end
            6'h01: begin
                m_res = alu_input_a - alu_input_b;
                m_ovf = (alu_input_a[W-1] != alu_input_b[W-1]) && (m_res[W-1] != alu_input_a[W-1]);
            end
            6'h20: m_res = alu_input_a & alu_input_b;
            6'h21: m_res = alu_input_a | alu_input_b;
            6'h22: m_res = alu_input_a ^ alu_input_b;
            default: m_res = alu_input_a | alu_input_b;
        endcase
    end
    assign alu_result = m_res;
    assign alu_flags  = {m_ovf, alu_input_a == alu_input_b, alu_input_a != alu_input_b,
                         $signed(alu_input_a) > $signed(alu_input_b),
                         $signed(alu_input_a) < $signed(alu_input_b),
                         alu_input_a == alu_input_b, alu_input_a > alu_input_b,
                         alu_input_a < alu_input_b};

    task automatic set_req(input int i, input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_operation[i*6 +: 6] = op;
        req_input_a[i*W +: W]   = a;
        req_input_b[i*W +: W]   = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
        tests_run++; if (alu_operation !== 6'h00) begin tests_failed++; $display("FAIL reset_alu_op got %0h want 0", alu_operation); end
        tests_run++; if (alu_input_a !== '0 || alu_input_b !== '0) begin tests_failed++; $display("FAIL reset_alu_ab got %0h/%0h want 0/0", alu_input_a, alu_input_b); end
        tests_run++; if (rsp_result !== '0 || rsp_flags !== 8'h00) begin tests_failed++; $display("FAIL reset_rsp_data got %0h/%0h want 0/0", rsp_result, rsp_flags); end
        tests_run++; if (rsp_id !== 1'b0 || rsp_error !== 1'b0) begin tests_failed++; $display("FAIL reset_id_err got %0d/%0b want 0/0", rsp_id, rsp_error); end
        tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_ready_idle got %b want 00", req_ready); end
        req_valid = 2'b11;
        #1;
        tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL reset_ready_grant got %b want 01", req_ready); end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_op();
        set_req(0, 6'h00, 64'd5, 64'd7);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL single_ready got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        tests_run++; if (alu_input_a !== 64'd5 || alu_input_b !== 64'd7 || alu_operation !== 6'h00) begin tests_failed++; $display("FAIL single_alu_in got %0d/%0d/%0h want 5/7/0", alu_input_a, alu_input_b, alu_operation); end
        tests_run++; if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin tests_failed++; $display("FAIL single_exec got valid=%0b ready=%b want 0/00", rsp_valid, req_ready); end
        @(negedge clk);
        #1;
        $display("[TB] txn single id=%0d result=%0d flags=%02h err=%0b", rsp_id, rsp_result, rsp_flags, rsp_error);
        tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL single_rsp_valid got %0b want 1", rsp_valid); end
        tests_run++; if (rsp_result !== 64'd12 || rsp_id !== 1'b0) begin tests_failed++; $display("FAIL single_rsp got %0d id %0d want 12 id 0", rsp_result, rsp_id); end
        tests_run++; if (rsp_flags !== 8'h29 || rsp_error !== 1'b0) begin tests_failed++; $display("FAIL single_flags got %02h err %0b want 29 err 0", rsp_flags, rsp_error); end
        @(negedge clk);
        #1;
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL single_rsp_clear got %0b want 0", rsp_valid); end
    endtask

    task automatic test_contention();
        logic [1:0]   exp_g;
        logic [W-1:0] exp_r;
        do_reset();
        set_req(0, 6'h00, 64'd10, 64'd3);
        set_req(1, 6'h01, 64'd20, 64'd4);
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
            exp_r = (n % 2 == 0) ? 64'd13 : 64'd16;
            #1;
            tests_run++; if (req_ready !== exp_g) begin tests_failed++; $display("FAIL contention_grant%0d got %b want %b", n, req_ready, exp_g); end
            @(negedge clk);
            @(negedge clk);
            #1;
            $display("[TB] txn contention%0d id=%0d result=%0d flags=%02h", n, rsp_id, rsp_result, rsp_flags);
            tests_run++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(n % 2)) begin tests_failed++; $display("FAIL contention_id%0d got valid=%0b id=%0d want 1/%0d", n, rsp_valid, rsp_id, n % 2); end
            tests_run++; if (rsp_result !== exp_r || rsp_flags !== 8'h32) begin tests_failed++; $display("FAIL contention_res%0d got %0d/%02h want %0d/32", n, rsp_result, rsp_flags, exp_r); end
            if (n == 3) req_valid = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        set_req(0, 6'h00, 64'd1, 64'd2);
        set_req(1, 6'h22, 64'hF0, 64'hFF);
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        #1;
        tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL bp_grant got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b10;
        @(negedge clk);
        #1;
        tests_run++; if (rsp_valid !== 1'b1 || rsp_result !== 64'd3) begin tests_failed++; $display("FAIL bp_first got %0b/%0d want 1/3", rsp_valid, rsp_result); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            tests_run++; if (rsp_valid !== 1'b1 || rsp_result !== 64'd3 || rsp_id !== 1'b0 || req_ready !== 2'b00) begin
                tests_failed++; $display("FAIL bp_hold%0d got valid=%0b res=%0d id=%0d ready=%b want 1/3/0/00", k, rsp_valid, rsp_result, rsp_id, req_ready);
            end
        end
        $display("[TB] txn backpressure id=%0d result=%0d", rsp_id, rsp_result);
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        tests_run++; if (rsp_valid !== 1'b0 || rsp_result !== 64'd3) begin tests_failed++; $display("FAIL bp_retain got valid=%0b res=%0d want 0/3", rsp_valid, rsp_result); end
        tests_run++; if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL bp_next_grant got %b want 10", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        tests_run++; if (alu_operation !== 6'h22 || alu_input_a !== 64'hF0) begin tests_failed++; $display("FAIL bp_exec_in got %0h/%0h want 22/f0", alu_operation, alu_input_a); end
        @(negedge clk);
        #1;
        $display("[TB] txn backpressure id=%0d result=%0h", rsp_id, rsp_result);
        tests_run++; if (rsp_valid !== 1'b1 || rsp_result !== 64'h0F || rsp_id !== 1'b1) begin tests_failed++; $display("FAIL bp_second got %0b/%0h/%0d want 1/f/1", rsp_valid, rsp_result, rsp_id); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        set_req(0, 6'h00, 64'd4, 64'd4);
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        #1;
        tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL areset_grant got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #2;
        tests_run++; if (alu_input_a !== 64'd4) begin tests_failed++; $display("FAIL areset_exec_in got %0d want 4", alu_input_a); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (rsp_valid !== 1'b0 || alu_input_a !== '0) begin tests_failed++; $display("FAIL areset_clear got valid=%0b a=%0d want 0/0", rsp_valid, alu_input_a); end
        req_valid = 2'b11;
        #1;
        tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL areset_ptr got %b want 01", req_ready); end
        req_valid = '0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_stale%0d got %0b want 0", k, rsp_valid); end
        end
    endtask

    task automatic test_signed_flags();
        set_req(0, 6'h01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        #1;
        tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL signed_grant got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        tests_run++; if (alu_operation !== 6'h01 || alu_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin tests_failed++; $display("FAIL signed_exec got op=%0h res=%0h want 1/fffffffffffffffe", alu_operation, alu_result); end
        @(negedge clk);
        #1;
        $display("[TB] txn signed id=%0d result=%0h flags=%02h", rsp_id, rsp_result, rsp_flags);
        tests_run++; if (rsp_valid !== 1'b1 || rsp_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin tests_failed++; $display("FAIL signed_result got %0b/%0h want 1/fffffffffffffffe", rsp_valid, rsp_result); end
        tests_run++; if (rsp_flags !== 8'h2A || rsp_id !== 1'b0) begin tests_failed++; $display("FAIL signed_flags got %02h id %0d want 2a id 0", rsp_flags, rsp_id); end
        @(negedge clk);
    endtask

    task automatic test_opcode_check();
        set_req(1, 6'h3F, 64'd9, 64'd9);
        rsp_ready = 1'b1;
        req_valid = 2'b10;
        #1;
        tests_run++; if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL opcheck_grant got %b want 10", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
`ifdef ALU_ARB_OPCHECK_EN
        $display("[TB] txn opcheck id=%0d result=%0h err=%0b", rsp_id, rsp_result, rsp_error);
        tests_run++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin tests_failed++; $display("FAIL opcheck_err got valid=%0b err=%0b want 1/1", rsp_valid, rsp_error); end
        tests_run++; if (rsp_result !== '0 || rsp_flags !== 8'h00 || rsp_id !== 1'b1) begin tests_failed++; $display("FAIL opcheck_zero got %0h/%02h/%0d want 0/00/1", rsp_result, rsp_flags, rsp_id); end
        tests_run++; if (alu_operation !== 6'h01) begin tests_failed++; $display("FAIL opcheck_op_hold got %0h want 01", alu_operation); end
        @(negedge clk);
        #1;
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL opcheck_clear got %0b want 0", rsp_valid); end
`else
        tests_run++; if (rsp_valid !== 1'b0 || alu_operation !== 6'h3F) begin tests_failed++; $display("FAIL opcheck_exec got valid=%0b op=%0h want 0/3f", rsp_valid, alu_operation); end
        @(negedge clk);
        #1;
        $display("[TB] txn opcheck id=%0d result=%0h err=%0b", rsp_id, rsp_result, rsp_error);
        tests_run++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0) begin tests_failed++; $display("FAIL opcheck_noerr got valid=%0b err=%0b want 1/0", rsp_valid, rsp_error); end
        tests_run++; if (rsp_result !== 64'd9 || rsp_flags !== 8'h44 || rsp_id !== 1'b1) begin tests_failed++; $display("FAIL opcheck_pass got %0h/%02h/%0d want 9/44/1", rsp_result, rsp_flags, rsp_id); end
        @(negedge clk);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", tests_run);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_async_reset();
        test_signed_flags();
        test_opcode_check();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_access_arbiter.md
Name: alu_access_arbiter

Overview:
- Shares the single combinational ALU between NUM_REQ requesters (e.g. integer pipe, address generation, branch unit).
- Arbitrates round-robin, accepts one operation per grant, and registers the operands onto the ALU inputs.
- Captures result plus all eight flags after one execute cycle, then returns them on a valid/ready response channel tagged with the requester index.

Parameters:
- WORDSIZE, 64, datapath width; must match the ALU instance.
- NUM_REQ, 2, number of requesters, range 2..8.
- ID_W, $clog2(NUM_REQ), width of the response tag.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_input_a  in  NUM_REQ*WORDSIZE  packed operand A; slice i belongs to requester i.
- req_input_b  in  NUM_REQ*WORDSIZE  packed operand B.
- req_operation  in  NUM_REQ*6  packed 6-bit ALU opcodes.
- alu_input_a  out  WORDSIZE  to ALU input_a.
- alu_input_b  out  WORDSIZE  to ALU input_b.
- alu_operation  out  6  to ALU operation.
- alu_result  in  WORDSIZE  from ALU result.
- alu_flags  in  8  from ALU flags: {overflow, equal, not_equal, greater, less, u_equal, u_greater, u_less}, bit 7 down to 0.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester served.
- rsp_result  out  WORDSIZE  captured result.
- rsp_flags  out  8  captured flags, same order as alu_flags.
- rsp_error  out  1  illegal-opcode indication.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low; assertion immediately clears all state.
- Reset values:
  - State = IDLE, round-robin pointer = 0.
  - alu_input_a/b, alu_operation, rsp_result, rsp_flags, rsp_id, rsp_error = 0; rsp_valid = 0.
  - req_ready follows IDLE combinationally.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational: the first asserted req_valid at or after the pointer, searching upward with wrap.
  - req_ready = grant one-hot; all zero if no req_valid or state != IDLE.
  - On a handshake (req_valid[i] & req_ready[i]), register slice i onto alu_input_a/b/alu_operation, register i as the id, set pointer = (i+1) mod NUM_REQ, and go to EXEC.
- EXEC (exactly 1 cycle):
  - ALU inputs are held stable.
  - At the clock edge, capture alu_result and alu_flags into the rsp_* registers, set rsp_valid=1, and go to RESP.
- RESP:
  - rsp_* outputs are held stable while rsp_valid=1 and rsp_ready=0 (backpressure is unbounded).
  - When rsp_valid & rsp_ready, clear rsp_valid and go to IDLE.
  - rsp_result/flags/id retain their last values after the handshake.
- Timing:
  - Latency from request accept to rsp_valid = 2 clocks.
  - Peak throughput = 1 operation per 3 clocks.
  - req_ready is never asserted in EXEC or RESP.
- ALU input stability: alu_input_* change only on an accept edge and are stable from EXEC through RESP.
- Fairness:
  - A requester holding req_valid is granted within NUM_REQ grants.
  - req_valid dropped before its grant is legal; no accept occurs.
- Single requester: the same index is granted repeatedly; the pointer wraps past it.
- Reset during EXEC or RESP: the transaction is discarded, no response is produced, and the pointer returns to 0.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- Legal opcode set:
  - 0x00–0x04 (integer arithmetic).
  - 0x10–0x12 (floating-point arithmetic).
  - 0x20–0x23 (bitwise).
  - 0x30–0x33 (bitshift).
- Defined:
  - An accept with an illegal opcode goes IDLE -> RESP directly, skipping EXEC.
  - rsp_result=0, rsp_flags=0, rsp_error=1; alu_operation is not updated.
  - Legal opcodes give rsp_error=0.
- Undefined:
  - No check is made; every opcode passes through EXEC.
  - rsp_error is tied 0 and the port remains present.

Decomposition:
- Package alu_pkg:
  - The 6-bit opcode localparams and the unit-select field [5:4].
  - Flag bit indices 0..7.
  - FSM state encoding.
  - A function is_legal_op(op).
- Sub-module alu_rr_arbiter:
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; reusable by other shared-resource controllers.

Test Plan:
- Reset then single op: req0 sends add, A=5, B=7, rsp_ready=1 -> req_ready[0] in cycle 0; alu_operation=0x00 from cycle 1; rsp_valid in cycle 2 with result 12, id=0, flags equal=0, less=1, u_less=1.
- Contention: req0 and req1 held valid with distinct ops -> grants alternate 0,1,0,1 and rsp_id alternates to match.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0 throughout; accept of the next request only after the response handshake.
- Async reset: rst_n pulsed low mid-EXEC -> rsp_valid=0 and pointer=0 immediately; no stale response after release.
- Opcode check: with ALU_ARB_OPCHECK_EN, op 0x3F -> response 1 cycle after accept with rsp_error=1, result 0; without the macro, same stimulus -> normal 2-cycle path with rsp_error=0.
- Signed flags: sub on A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> rsp_flags less=1, u_greater=1, not_equal=1, and captured result equals the ALU output in EXEC.
